// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down-counter with parallel load, borrow out,
// one-cycle zero-reached pulse and sticky illegal-load flag.
module bcd_down_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  Clear,
    input  logic [4*DIGITS-1:0]   Data_in,
    input  logic                  Load,
    input  logic                  Count,
    output logic [4*DIGITS-1:0]   A_count,
    output logic                  B_out,
    output logic                  Zero,
    output logic                  Done,
    output logic                  Err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [W-1:0] dec_val;
    logic [W-1:0] load_val;
    logic         load_bad;
    logic         borrow;
    logic         is_zero;
    logic         is_one;

    assign is_zero = (count_q == '0);
    assign is_one  = (count_q == W'(1));

    // Ripple the borrow from digit 0 until a non-zero digit absorbs it.
    always_comb begin
        dec_val = count_q;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Out-of-range load digits saturate to 9 so the count stays legal BCD.
    always_comb begin
        load_val = Data_in;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (Data_in[4*i +: 4] > 4'd9) begin
                load_val[4*i +: 4] = 4'd9;
                load_bad           = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (Clear) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (Load) begin
            count_d = load_val;
            err_d   = load_bad;
        end else if (Count) begin
            count_d = dec_val;
            done_d  = is_one;
        end
    end

    always_ff @(posedge CLK) begin
        count_q <= count_d;
        done_q  <= done_d;
        err_q   <= err_d;
    end

    assign A_count = count_q;
    assign Zero    = is_zero;
    assign B_out   = Count && !Load && is_zero;
    assign Done    = done_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter with DIGITS = 4.
module tb_bcd_down_counter;

    logic        CLK = 1'b0;
    logic        Clear = 1'b1;
    logic [15:0] Data_in = '0;
    logic        Load = 1'b0;
    logic        Count = 1'b0;
    logic [15:0] A_count;
    logic        B_out;
    logic        Zero;
    logic        Done;
    logic        Err;

    int tests = 0;
    int fails = 0;

    bcd_down_counter #(.DIGITS(4)) dut (
        .CLK     (CLK),
        .Clear   (Clear),
        .Data_in (Data_in),
        .Load    (Load),
        .Count   (Count),
        .A_count (A_count),
        .B_out   (B_out),
        .Zero    (Zero),
        .Done    (Done),
        .Err     (Err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        step();
        step();
        check("rst_count", 32'(A_count), 32'h0000);
        check("rst_zero", 32'(Zero), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        Count = 1'b1;
        #1;
        check("rst_bout", 32'(B_out), 32'd1);
        Clear = 1'b0;
        Count = 1'b0;

        // Borrow ripple
        Load = 1'b1;
        Data_in = 16'h1000;
        step();
        check("ld_1000", 32'(A_count), 32'h1000);
        Load = 1'b0;
        Count = 1'b1;
        #1;
        check("bout_nz", 32'(B_out), 32'd0);
        check("zero_nz", 32'(Zero), 32'd0);
        step();
        Count = 1'b0;
        check("dec_1000", 32'(A_count), 32'h0999);
        Load = 1'b1;
        Data_in = 16'h0100;
        step();
        Load = 1'b0;
        Count = 1'b1;
        step();
        Count = 1'b0;
        check("dec_0100", 32'(A_count), 32'h0099);

        // Count to zero, Done pulse, wrap
        Load = 1'b1;
        Data_in = 16'h0003;
        step();
        Load = 1'b0;
        check("ld3_done", 32'(Done), 32'd0);
        Count = 1'b1;
        step();
        check("cz_2", 32'(A_count), 32'h0002);
        check("cz_2_done", 32'(Done), 32'd0);
        step();
        check("cz_1", 32'(A_count), 32'h0001);
        check("cz_1_done", 32'(Done), 32'd0);
        step();
        check("cz_0", 32'(A_count), 32'h0000);
        check("cz_0_done", 32'(Done), 32'd1);
        check("cz_0_zero", 32'(Zero), 32'd1);
        check("cz_0_bout", 32'(B_out), 32'd1);
        step();
        check("cz_wrap", 32'(A_count), 32'h9999);
        check("cz_wrap_done", 32'(Done), 32'd0);
        Count = 1'b0;
        step();
        check("idle_hold", 32'(A_count), 32'h9999);

        // Illegal load
        Load = 1'b1;
        Data_in = 16'h12F4;
        step();
        Load = 1'b0;
        check("ill_count", 32'(A_count), 32'h1294);
        check("ill_err", 32'(Err), 32'd1);
        Count = 1'b1;
        step();
        Count = 1'b0;
        check("ill_dec", 32'(A_count), 32'h1293);
        check("ill_err_cnt", 32'(Err), 32'd1);
        step();
        check("ill_err_idle", 32'(Err), 32'd1);
        Load = 1'b1;
        Data_in = 16'h0005;
        step();
        Load = 1'b0;
        check("ok_count", 32'(A_count), 32'h0005);
        check("ok_err", 32'(Err), 32'd0);

        // Priority
        Load = 1'b1;
        Data_in = 16'h0000;
        step();
        check("ld0_count", 32'(A_count), 32'h0000);
        check("ld0_done", 32'(Done), 32'd0);
        Count = 1'b1;
        Data_in = 16'h0042;
        #1;
        check("pri_bout", 32'(B_out), 32'd0);
        step();
        check("pri_count", 32'(A_count), 32'h0042);
        check("pri_done", 32'(Done), 32'd0);
        Count = 1'b0;
        Clear = 1'b1;
        step();
        check("clr_ld", 32'(A_count), 32'h0000);
        Clear = 1'b0;
        Load = 1'b0;

        // Mid-operation reset
        Load = 1'b1;
        Data_in = 16'h0002;
        step();
        Load = 1'b0;
        Count = 1'b1;
        step();
        check("mid_1", 32'(A_count), 32'h0001);
        Clear = 1'b1;
        step();
        check("mid_clr", 32'(A_count), 32'h0000);
        check("mid_done0", 32'(Done), 32'd0);
        Clear = 1'b0;
        Count = 1'b0;
        step();
        check("mid_done1", 32'(Done), 32'd0);
        Count = 1'b1;
        step();
        Count = 1'b0;
        check("mid_wrap", 32'(A_count), 32'h9999);
        check("mid_wrap_done", 32'(Done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Multi-digit synchronous BCD down-counter with parallel load and a borrow output, the decrementing counterpart to the team's BCD up-counter. It counts down through a packed BCD value one step per enabled clock and raises a borrow when the count underflows, so stages can be chained least-significant first. It reports reaching zero with a one-cycle Done pulse, and it flags non-BCD load data. It sits in timer and countdown datapaths fed by keypad or switch BCD values.

## Interface
- DIGITS, 4: number of BCD digits. Legal range is 1–8.
- CLK  input  1: clock; all state updates on the rising edge.
- Clear  input  1: synchronous, active-high reset. Highest priority.
- Data_in  input  4*DIGITS: packed BCD load value. Digit 0 occupies bits [3:0].
- Load  input  1: active high. Loads Data_in.
- Count  input  1: active high. Decrements by one.
- A_count  output  4*DIGITS: registered count, packed BCD.
- B_out  output  1: combinational borrow, equal to Count && !Load && (A_count == 0).
- Zero  output  1: combinational, equal to (A_count == 0).
- Done  output  1: registered one-cycle pulse on a counted 1 -> 0 transition.
- Err  output  1: registered, sticky. Set when a load carried an illegal digit.

## Operation
- The following priority is evaluated at each rising edge of CLK:
  - Clear = 1: A_count = 0, Done = 0, Err = 0.
  - Else if Load = 1: each digit i loads Data_in[4i+3:4i].
    - A digit value of 10–15 loads as 9 instead.
    - Err = 1 if any digit was 10–15. Otherwise Err = 0, so a valid load clears Err.
    - Done = 0.
  - Else if Count = 1: A_count is decremented in BCD.
    - Digit 0 decrements.
    - A digit at 0 becomes 9 and borrows from the next digit.
    - A digit at 1–9 decrements and stops the borrow.
    - Digits above the stopping point are unchanged.
  - Else: A_count holds.
- Underflow: Count while A_count = 0 wraps to all nines (9999 for DIGITS = 4). B_out is high during that cycle.
- Done = 1 for exactly one cycle, the cycle after an edge where Count = 1, Load = 0 and A_count went from 1 to 0. Otherwise Done = 0.
  - Loading zero does not pulse Done.
  - Wrapping from 0 does not pulse Done.
- Err is unaffected by Count and by idle cycles.
- The block holds A_count in BCD at all times. The arithmetic never produces an illegal digit, whatever the input.
- Chaining: drive the Count input of the next-higher stage from B_out. A borrow takes effect in the higher stage at the same edge as the wrap in the lower stage.

## Timing
- Reset values: A_count = 0, Done = 0, Err = 0. With these values, Zero = 1, and B_out = Count && !Load.
- Latency: one cycle from Load or Count to A_count. Done follows one cycle after the edge that reached zero.
- B_out and Zero are purely combinational from A_count, Count and Load. There are no registered versions.
- Simultaneous events:
  - Clear overrides Load and Count.
  - Load overrides Count. B_out is forced low while Load = 1.
- Clear asserted mid-count: the count resets at that edge and any pending Done is suppressed. Counting resumes from 0 on the first Count after Clear deasserts, and that first step wraps to nines.
- The Count input is a level, not an edge. Holding Count high decrements once per clock.

## Test plan
- Reset with DIGITS = 4: assert Clear for 2 cycles -> A_count = 0000, Zero = 1, Done = 0, Err = 0. With Count = 1, B_out = 1.
- Borrow ripple: Load 1000, then Count for one cycle -> A_count = 0999. Load 0100, then Count -> A_count = 0099.
- Count to zero: Load 0003, then hold Count -> A_count steps 0002, 0001, 0000. Done = 1 only in the cycle after the 0001 -> 0000 edge. Then A_count wraps to 9999 with B_out = 1 during the 0000 cycle.
- Illegal load: Data_in = 0x12F4 -> A_count = 1294 and Err = 1. Then Count -> A_count = 1293 and Err stays 1. Then a valid Load 0005 -> Err = 0.
- Priority: Load = 1, Count = 1, Data_in = 0042 while A_count = 0000 -> A_count = 0042, B_out = 0, no Done. Clear = 1 and Load = 1 together -> A_count = 0000.
- Mid-operation reset: Load 0002, Count 1 cycle (A_count = 0001), then Clear on the cycle where Count would reach zero -> A_count = 0000 and Done never pulses.
